// File: rtl/filter_row_sched_pkg.sv
// Shared types and constants for the filter row scheduler.
// Optional per-row type input: FILTER_ROW_SCHED_TYPE_CFG_EN.
package filter_row_sched_pkg;

  localparam int SIZE_W_WD = 13;
  localparam int SIZE_H_WD = 13;
  localparam int TYPE_WD   = 3;

  localparam logic [TYPE_WD-1:0] FLT_NONE  = TYPE_WD'(0);
  localparam logic [TYPE_WD-1:0] FLT_SUB   = TYPE_WD'(1);
  localparam logic [TYPE_WD-1:0] FLT_UP    = TYPE_WD'(2);
  localparam logic [TYPE_WD-1:0] FLT_AVG   = TYPE_WD'(3);
  localparam logic [TYPE_WD-1:0] FLT_PAETH = TYPE_WD'(4);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEAD,
    ST_ROW,
    ST_GAP,
    ST_FIN
  } state_e;

  // Row 0 has no previous row, so any type that needs one falls back to Sub.
  function automatic logic [TYPE_WD-1:0] flt_type_fix(
    input logic [TYPE_WD-1:0] code,
    input logic               row0
  );
    logic [TYPE_WD-1:0] t;
    t = code;
    if (code > FLT_PAETH)
      t = FLT_NONE;
    else if (row0 && code != FLT_NONE)
      t = FLT_SUB;
    return t;
  endfunction

endpackage

// File: rtl/filter_row_cnt.sv
// Column/row counter pair with last-pixel and last-row flags.
// Limits are stored as cfg-1 so a full-width width never wraps early.
module filter_row_cnt
  import filter_row_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [SIZE_W_WD-1:0] cfg_w,
  input  logic [SIZE_H_WD-1:0] cfg_h,
  input  logic                 inc_w,
  input  logic                 inc_h,
  output logic [SIZE_W_WD-1:0] cnt_w,
  output logic [SIZE_H_WD-1:0] cnt_h,
  output logic                 last_w,
  output logic                 last_h
);

  logic [SIZE_W_WD-1:0] lim_w;
  logic [SIZE_H_WD-1:0] lim_h;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lim_w <= '0;
      lim_h <= '0;
      cnt_w <= '0;
      cnt_h <= '0;
    end else if (load) begin
      lim_w <= cfg_w - 1'b1;
      lim_h <= cfg_h - 1'b1;
      cnt_w <= '0;
      cnt_h <= '0;
    end else begin
      if (inc_w)
        cnt_w <= last_w ? '0 : cnt_w + 1'b1;
      if (inc_h)
        cnt_h <= cnt_h + 1'b1;
    end
  end

  assign last_w = (cnt_w == lim_w);
  assign last_h = (cnt_h == lim_h);

endmodule

// File: rtl/filter_row_sched.sv
// Row sequencer: frame start, per-row type slot, pixel pacing, drain gap.
// Define FILTER_ROW_SCHED_TYPE_CFG_EN to add the cfg_type_i input.
module filter_row_sched
  import filter_row_sched_pkg::*;
#(
  parameter int GAP_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SIZE_W_WD-1:0] cfg_w_i,
  input  logic [SIZE_H_WD-1:0] cfg_h_i,
`ifdef FILTER_ROW_SCHED_TYPE_CFG_EN
  input  logic [TYPE_WD-1:0]   cfg_type_i,
`endif
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  input  logic                 src_val_i,
  output logic                 src_rdy_o,
  output logic                 flt_start_o,
  output logic                 flt_val_o,
  output logic                 row_head_o,
  output logic [TYPE_WD-1:0]   row_type_o,
  output logic [SIZE_W_WD-1:0] cnt_w_o,
  output logic [SIZE_H_WD-1:0] cnt_h_o,
  output logic                 bank_o
);

  localparam int GAP_WD = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_WD-1:0] GAP_LAST = GAP_WD'(GAP_CYC - 1);

  state_e             state;
  state_e             state_nxt;
  logic [GAP_WD-1:0]  gap_cnt;
  logic               load;
  logic               zero_cfg;
  logic               xfer;
  logic               gap_last;
  logic               inc_h;
  logic               last_w;
  logic               last_h;
  logic [TYPE_WD-1:0] row_type;

  assign load     = (state == ST_IDLE) && start_i;
  assign zero_cfg = (cfg_w_i == '0) || (cfg_h_i == '0);
  assign xfer     = (state == ST_ROW) && src_val_i;
  assign gap_last = (gap_cnt == GAP_LAST);
  assign inc_h    = (state == ST_GAP) && gap_last;

  filter_row_cnt u_cnt (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .cfg_w  (cfg_w_i),
    .cfg_h  (cfg_h_i),
    .inc_w  (xfer),
    .inc_h  (inc_h),
    .cnt_w  (cnt_w_o),
    .cnt_h  (cnt_h_o),
    .last_w (last_w),
    .last_h (last_h)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      gap_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_GAP && !gap_last)
        gap_cnt <= gap_cnt + 1'b1;
      else
        gap_cnt <= '0;
    end
  end

  always_comb begin
    state_nxt   = state;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    src_rdy_o   = 1'b0;
    flt_start_o = 1'b0;
    row_head_o  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_i) begin
          flt_start_o = 1'b1;
          state_nxt   = zero_cfg ? ST_FIN : ST_HEAD;
        end
      end
      ST_HEAD: begin
        busy_o     = 1'b1;
        row_head_o = 1'b1;
        state_nxt  = ST_ROW;
      end
      ST_ROW: begin
        busy_o    = 1'b1;
        src_rdy_o = 1'b1;
        if (src_val_i && last_w)
          state_nxt = last_h ? ST_FIN : ST_GAP;
      end
      ST_GAP: begin
        busy_o = 1'b1;
        if (gap_last)
          state_nxt = ST_HEAD;
      end
      ST_FIN: begin
        done_o    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef FILTER_ROW_SCHED_TYPE_CFG_EN
  assign row_type = flt_type_fix(cfg_type_i, cnt_h_o == '0);
`else
  assign row_type = (cnt_h_o == '0) ? FLT_SUB : FLT_UP;
`endif

  assign row_type_o = row_head_o ? row_type : '0;
  assign flt_val_o  = xfer;
  assign bank_o     = cnt_h_o[0];

endmodule
